// File: rtl/spi_shift_engine_if.sv
// Bus bundle between spi_shift_engine and its controller, clock divider and SPI slave.
interface spi_shift_engine_if;
    logic [7:0] i_data;
    logic       i_load;
    logic       o_div_start_n;
    logic       i_sclk;
    logic       i_div_idle;
    logic       i_miso;
    logic       o_mosi;
    logic       o_cs_n;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;

    // Engine side of the bus.
    modport slave (
        input  i_data, i_load, i_sclk, i_div_idle, i_miso,
        output o_div_start_n, o_mosi, o_cs_n, o_data, o_valid, o_busy
    );

    // Controller / environment side of the bus.
    modport master (
        output i_data, i_load, i_sclk, i_div_idle, i_miso,
        input  o_div_start_n, o_mosi, o_cs_n, o_data, o_valid, o_busy
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shift engine: frames one byte under chip select, starts an
// external clock divider, shifts on detected SCLK edges and reports the
// received byte with a one-cycle valid pulse.
module spi_shift_engine #(
    parameter int unsigned CS_LEAD   = 2,
    parameter int unsigned CS_LAG    = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    spi_shift_engine_if.slave io_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_START,
        S_XFER,
        S_LAG,
        S_DONE
    } state_t;

    localparam logic [3:0] LEAD_LAST = 4'(CS_LEAD - 1);
    localparam logic [3:0] LAG_LAST  = 4'(CS_LAG - 1);

    state_t     r_state;
    logic       r_sclk_q;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [3:0] r_bit_cnt;
    logic [3:0] r_wait;
    logic       r_cs_n;
    logic       r_div_start_n;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_busy;

    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_tx_shift;
    logic [7:0] w_rx_shift;

    // Edge detection on the divided clock and next-value shift patterns.
    always_comb begin
        w_rise     = io_bus.i_sclk & ~r_sclk_q;
        w_fall     = ~io_bus.i_sclk & r_sclk_q;
        w_tx_shift = MSB_FIRST ? {r_tx[6:0], 1'b0} : {1'b0, r_tx[7:1]};
        w_rx_shift = MSB_FIRST ? {r_rx[6:0], io_bus.i_miso} : {io_bus.i_miso, r_rx[7:1]};
    end

    // Frame sequencer; MOSI is taken straight from the tx register's outgoing
    // bit so it only moves when tx is loaded or shifted on a detected fall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_sclk_q      <= 1'b0;
            r_tx          <= '0;
            r_rx          <= '0;
            r_bit_cnt     <= '0;
            r_wait        <= '0;
            r_cs_n        <= 1'b1;
            r_div_start_n <= 1'b1;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_sclk_q <= io_bus.i_sclk;
            r_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cs_n        <= 1'b1;
                    r_div_start_n <= 1'b1;
                    if (io_bus.i_load) begin
                        r_tx      <= io_bus.i_data;
                        r_rx      <= '0;
                        r_bit_cnt <= '0;
                        r_wait    <= '0;
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (r_wait == LEAD_LAST) begin
                        r_div_start_n <= 1'b0;
                        r_state       <= S_START;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_START: begin
                    r_div_start_n <= 1'b1;
                    r_state       <= S_XFER;
                end
                S_XFER: begin
                    if (w_rise && (r_bit_cnt < 4'd8)) begin
                        r_rx      <= w_rx_shift;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    if (w_fall && (r_bit_cnt < 4'd8)) begin
                        r_tx <= w_tx_shift;
                    end
                    // Divider idle is only trusted once all eight bits are in,
                    // which hides its start-up idle latency.
                    if ((r_bit_cnt == 4'd8) && io_bus.i_div_idle) begin
                        r_wait  <= '0;
                        r_state <= S_LAG;
                    end
                end
                S_LAG: begin
                    if (r_wait == LAG_LAST) begin
                        r_cs_n  <= 1'b1;
                        r_data  <= r_rx;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.o_div_start_n = r_div_start_n;
    assign io_bus.o_mosi        = MSB_FIRST ? r_tx[7] : r_tx[0];
    assign io_bus.o_cs_n        = r_cs_n;
    assign io_bus.o_data        = r_data;
    assign io_bus.o_valid       = r_valid;
    assign io_bus.o_busy        = r_busy;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: an MSB-first and an LSB-first engine
// run side by side against a behavioural clock divider and MSB-first slave.
module tb_spi_shift_engine;

    localparam int unsigned LEAD  = 3;
    localparam int unsigned LAG   = 4;
    localparam int          LIMIT = 6000;

    typedef struct {
        logic [7:0] dm;
        logic [7:0] dl;
        logic [7:0] sm;
        logic [7:0] sl;
        bit         chk_slave;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [7:0]  ld_data = 8'h00;
    logic        ld = 1'b0;
    logic        loopback = 1'b0;
    logic [7:0]  resp = 8'h00;
    int          divisor = 4;
    int          idle_lat = 0;
    bit          extra = 1'b0;

    logic        sclk = 1'b0;
    logic        div_idle = 1'b1;
    logic        slave_bit = 1'b0;
    int          k = 8;
    logic [7:0]  srx_m = 8'h00;
    logic [7:0]  srx_l = 8'h00;
    int          rises_m = 0;
    int          rises_l = 0;

    exp_t        exp_q[$];
    int unsigned start_q[$];

    spi_shift_engine_if ifm ();
    spi_shift_engine_if ifl ();

    assign ifm.i_data     = ld_data;
    assign ifl.i_data     = ld_data;
    assign ifm.i_load     = ld;
    assign ifl.i_load     = ld;
    assign ifm.i_sclk     = sclk;
    assign ifl.i_sclk     = sclk;
    assign ifm.i_div_idle = div_idle;
    assign ifl.i_div_idle = div_idle;
    assign ifm.i_miso     = loopback ? ifm.o_mosi : slave_bit;
    assign ifl.i_miso     = loopback ? ifl.o_mosi : slave_bit;

    spi_shift_engine #(.CS_LEAD(LEAD), .CS_LAG(LAG), .MSB_FIRST(1'b1)) u_dut_msb (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (ifm.slave)
    );

    spi_shift_engine #(.CS_LEAD(LEAD), .CS_LAG(LAG), .MSB_FIRST(1'b0)) u_dut_lsb (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (ifl.slave)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    // Behavioural clock divider plus MSB-first mode-0 slave.
    initial begin
        bit   sq[$];
        bit   iq[$];
        logic st;
        logic r;
        logic nv;
        logic [7:0] tmp;
        forever begin
            @(posedge clk);
            st = ifm.o_div_start_n;
            r  = rst;
            #1;
            if (r) begin
                sq.delete();
                iq.delete();
                sclk     = 1'b0;
                div_idle = 1'b1;
            end else begin
                if (!st) begin
                    sq.delete();
                    iq.delete();
                    sq.push_back(1'b0);
                    for (int p = 0; p < (extra ? 9 : 8); p++) begin
                        for (int h = 0; h < divisor / 2; h++) sq.push_back(1'b1);
                        for (int l = 0; l < divisor - divisor / 2; l++) sq.push_back(1'b0);
                    end
                    for (int i = 0; i < sq.size(); i++) iq.push_back(i < idle_lat);
                    k = 0; srx_m = 8'h00; srx_l = 8'h00; rises_m = 0; rises_l = 0;
                end
                if (sq.size() > 0) begin
                    nv       = sq.pop_front();
                    div_idle = iq.pop_front();
                    if (nv && !sclk) begin
                        srx_m = {srx_m[6:0], ifm.o_mosi};
                        srx_l = {srx_l[6:0], ifl.o_mosi};
                        if (!ifm.o_cs_n) rises_m++;
                        if (!ifl.o_cs_n) rises_l++;
                    end
                    if (!nv && sclk) k++;
                    sclk = nv;
                end else begin
                    sclk     = 1'b0;
                    div_idle = 1'b1;
                end
            end
            tmp       = resp << k;
            slave_bit = (k < 8) ? tmp[7] : 1'b0;
        end
    end

    // Monitor: pops expectations whenever the engines present a start pulse or a result.
    initial begin
        logic        prev_sclk;
        logic        hold_m;
        logic        hold_l;
        exp_t        e;
        int unsigned s;
        prev_sclk = 1'b0;
        hold_m    = 1'b0;
        hold_l    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sclk = 1'b0;
            end else begin
                if (!ifm.o_div_start_n || !ifl.o_div_start_n) begin
                    if (start_q.size() == 0) begin
                        check("unexpected_start", 32'(1), 32'(0));
                    end else begin
                        s = start_q.pop_front();
                        check("start_cycle", cyc, s);
                        check("start_both", 32'({ifm.o_div_start_n, ifl.o_div_start_n}), 32'(0));
                    end
                end
                if (ifm.o_valid || ifl.o_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("valid_both", 32'({ifm.o_valid, ifl.o_valid}), 32'(3));
                        check("data_msb", 32'(ifm.o_data), 32'(e.dm));
                        check("data_lsb", 32'(ifl.o_data), 32'(e.dl));
                        check("cs_n_done", 32'({ifm.o_cs_n, ifl.o_cs_n}), 32'(3));
                        if (e.chk_slave) begin
                            check("slave_rx_msb", 32'(srx_m), 32'(e.sm));
                            check("slave_rx_lsb", 32'(srx_l), 32'(e.sl));
                            check("rises_msb", 32'(rises_m), 32'(8));
                            check("rises_lsb", 32'(rises_l), 32'(8));
                        end
                    end
                end
                if (sclk && prev_sclk) begin
                    check("mosi_hold_msb", 32'(ifm.o_mosi), 32'(hold_m));
                    check("mosi_hold_lsb", 32'(ifl.o_mosi), 32'(hold_l));
                end
                if (sclk && !prev_sclk) begin
                    hold_m = ifm.o_mosi;
                    hold_l = ifl.o_mosi;
                end
                prev_sclk = sclk;
            end
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while ((ifm.o_busy || exp_q.size() != 0) && i < LIMIT) begin
            @(negedge clk);
            i++;
        end
        check("timeout_idle", 32'(ifm.o_busy), 32'(0));
    endtask

    task automatic wait_rises(input int n);
        int i;
        i = 0;
        while (rises_m != n && i < LIMIT) begin
            @(negedge clk);
            i++;
        end
        check("timeout_rises", 32'(rises_m), 32'(n));
    endtask

    function automatic void push_exp(input logic [7:0] tx, input logic [7:0] rsp, input bit lb, input bit xtra,
                                     input int unsigned start_at);
        exp_t e;
        e.dm        = lb ? tx : rsp;
        e.dl        = lb ? tx : rev8(rsp);
        e.sm        = tx;
        e.sl        = rev8(tx);
        e.chk_slave = !xtra;
        exp_q.push_back(e);
        start_q.push_back(start_at);
    endfunction

    task automatic do_load(input logic [7:0] tx, input logic [7:0] rsp, input bit lb, input int div, input bit xtra);
        wait_idle();
        resp     = rsp;
        loopback = lb;
        divisor  = div;
        extra    = xtra;
        idle_lat = int'($urandom_range(0, 2));
        ld_data  = tx;
        ld       = 1'b1;
        push_exp(tx, rsp, lb, xtra, cyc + LEAD + 1);
        @(negedge clk);
        ld      = 1'b0;
        ld_data = 8'($urandom);
    endtask

    initial begin
        int          i;
        logic [7:0]  r8;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'({ifm.o_cs_n, ifl.o_cs_n}), 32'(3));
        check("rst_start_n", 32'({ifm.o_div_start_n, ifl.o_div_start_n}), 32'(3));
        check("rst_mosi", 32'({ifm.o_mosi, ifl.o_mosi}), 32'(0));
        check("rst_data", 32'({ifm.o_data, ifl.o_data}), 32'(0));
        check("rst_valid_busy", 32'({ifm.o_valid, ifl.o_valid, ifm.o_busy, ifl.o_busy}), 32'(0));

        // Load together with reset is ignored.
        ld_data = 8'hFF;
        ld      = 1'b1;
        @(negedge clk);
        check("load_in_reset_busy", 32'(ifm.o_busy), 32'(0));
        rst = 1'b0;
        ld  = 1'b0;
        @(negedge clk);
        check("after_reset_idle", 32'({ifm.o_busy, ifm.o_cs_n}), 32'(1));

        do_load(8'hA5, 8'h00, 1'b1, 4, 1'b0);
        do_load(8'hC3, 8'h3C, 1'b0, 4, 1'b0);
        do_load(8'h5A, 8'($urandom), 1'b0, 2, 1'b0);
        do_load(8'h5A, 8'($urandom), 1'b0, 250, 1'b0);

        // Abort a frame after three rises.
        do_load(8'h96, 8'h69, 1'b0, 4, 1'b0);
        wait_rises(3);
        rst = 1'b1;
        exp_q.delete();
        start_q.delete();
        @(negedge clk);
        check("abort_cs_n", 32'({ifm.o_cs_n, ifl.o_cs_n}), 32'(3));
        check("abort_busy", 32'({ifm.o_busy, ifl.o_busy}), 32'(0));
        check("abort_data", 32'({ifm.o_data, ifl.o_data}), 32'(0));
        check("abort_valid", 32'({ifm.o_valid, ifl.o_valid}), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        do_load(8'h81, 8'($urandom), 1'b0, 4, 1'b0);

        // Stray loads during XFER and DONE, then an immediate reload.
        do_load(8'hFF, 8'($urandom), 1'b0, 4, 1'b0);
        wait_rises(2);
        ld_data = 8'h00;
        ld      = 1'b1;
        repeat (3) @(negedge clk);
        ld = 1'b0;
        i  = 0;
        while (!ifm.o_valid && i < LIMIT) begin
            @(negedge clk);
            i++;
        end
        check("timeout_valid", 32'(ifm.o_valid), 32'(1));
        ld_data = 8'h00;
        ld      = 1'b1;
        push_exp(8'h00, resp, 1'b0, 1'b0, cyc + 1 + LEAD + 1);
        @(negedge clk);
        @(negedge clk);
        ld = 1'b0;
        wait_idle();

        // Ninth divider pulse must not disturb the received byte.
        do_load(8'($urandom), 8'($urandom), 1'b0, 6, 1'b1);

        for (int n = 0; n < 20; n++) begin
            r8 = 8'($urandom);
            do_load(r8, 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(2, 12)),
                    ($urandom_range(0, 7) == 0));
        end
        wait_idle();
        check("scoreboard_drained", 32'(exp_q.size() + start_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter CS_LEAD, default 2: i_clk cycles between o_cs_n falling and the divider start pulse; legal range 1..15.
REQ-002 Parameter CS_LAG, default 2: i_clk cycles o_cs_n stays low after the transfer completes; legal range 1..15.
REQ-003 Parameter MSB_FIRST, default 1: 1 = bit 7 shifted first; 0 = bit 0 shifted first.
REQ-004 i_clk  in  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_data  in  8  byte to transmit; sampled when i_load is accepted.
REQ-007 i_load  in  1  request a frame; honoured only in IDLE.
REQ-008 o_div_start_n  out  1  active-low one-cycle start pulse to clock_divider i_start_n.
REQ-009 i_sclk  in  1  divided SPI clock from clock_divider o_clk.
REQ-010 i_div_idle  in  1  clock_divider o_idle.
REQ-011 i_miso  in  1  serial data from the slave.
REQ-012 o_mosi  out  1  serial data to the slave.
REQ-013 o_cs_n  out  1  active-low chip select.
REQ-014 o_data  out  8  last received byte; held until the next frame completes.
REQ-015 o_valid  out  1  one-cycle pulse; o_data is updated in the same cycle.
REQ-016 o_busy  out  1  high in every state except IDLE.

Function
REQ-017 SPI mode 0: the bench relies on i_sclk idling low, on the slave sampling MOSI on the SCLK rising edge, and on MOSI changing only after the SCLK falling edge.
REQ-018 Edge detection: register i_sclk to sclk_q; rise = i_sclk & ~sclk_q; fall = ~i_sclk & sclk_q; every divisor >= 2 is supported.
REQ-019 States: IDLE, LEAD, START, XFER, LAG, DONE; all outputs are registered.
REQ-020 IDLE: o_cs_n=1 and o_div_start_n=1; on i_load=1, load i_data into the tx shift register, clear the 4-bit bit counter and the rx register, drive o_cs_n=0, drive o_mosi with the first bit, and go to LEAD.
REQ-021 LEAD: hold for CS_LEAD cycles, then go to START.
REQ-022 START: drive o_div_start_n=0 for exactly one cycle, then go to XFER.
REQ-023 XFER, on rise: shift i_miso into rx (into the LSB if MSB_FIRST, else into the MSB) and increment the bit counter.
REQ-024 XFER, on fall with counter < 8: shift tx and drive the next bit onto o_mosi; on falls at counter = 8, o_mosi is held.
REQ-025 XFER exit: when counter = 8 and i_div_idle = 1, go to LAG; while counter < 8, i_div_idle is ignored (this covers divider idle-latency after start).
REQ-026 LAG: hold o_cs_n=0 for CS_LAG cycles, then go to DONE.
REQ-027 DONE: o_cs_n=1, o_data = rx, o_valid = 1 for one cycle, then go to IDLE; i_load in DONE is ignored.
REQ-028 i_load in any state other than IDLE is ignored; i_data is not resampled.
REQ-029 Latency: o_div_start_n goes low exactly CS_LEAD+1 cycles after the cycle in which i_load is accepted.
REQ-030 o_mosi changes only in IDLE→LEAD or on a detected fall; it never changes in a cycle where rise is detected.
REQ-031 Extra rising edges beyond 8 do not change rx or the counter; the counter saturates at 8.
REQ-032 Back-to-back frames: i_load asserted in the cycle after o_valid is accepted, giving a minimum of one IDLE cycle between frames.

Reset
REQ-033 In the cycle after i_rst=1 is sampled: state IDLE, o_cs_n=1, o_div_start_n=1, o_mosi=0, o_data=0x00, o_valid=0, o_busy=0, counter=0, sclk_q=0.
REQ-034 Reset mid-frame aborts the frame at once: o_cs_n=1, no o_valid pulse, and o_data=0x00.
REQ-035 i_load asserted together with i_rst is ignored.

Verification
REQ-036 Loopback: tie i_miso to o_mosi, divider divisor 4, load 0xA5 -> o_data=0xA5, exactly one o_valid pulse, exactly 8 rises while o_cs_n=0.
REQ-037 Slave model returns 0x3C while the engine sends 0xC3, MSB_FIRST=1 -> slave receives 0xC3 and o_data=0x3C; repeat with MSB_FIRST=0 -> bit order reversed on both sides.
REQ-038 Divisor 2, then divisor 250, each loading 0x5A -> correct o_data; o_mosi stable at every i_sclk rise; o_div_start_n low for one cycle, CS_LEAD+1 cycles after load.
REQ-039 Reset after 3 rises of a frame -> next cycle o_cs_n=1, o_busy=0, o_data=0x00; no o_valid pulse; the next load 0x81 completes correctly.
REQ-040 Load 0xFF, then assert i_load=1 with i_data=0x00 during XFER and during DONE -> transmitted byte remains 0xFF and only one frame occurs; an immediate reload after o_valid starts a second frame.
